ysyx_22041412_axi_rd_master: RTL
================================

Name: ysyx_22041412_axi_rd_master

Overview:
- AXI4 read-channel master that sits directly downstream of the read side of the AXI arbiter.
- Converts the arbiter's read request (r_valid_i/r_addr_i/r_len_i/r_size_i) into AR/R bus transactions.
- Returns each beat to the arbiter as r_ready_o/data_read_o, with r_last_i marking the final beat.
- A dropped request is never cancelled on the bus: it is always completed, and the beats are drained silently.

Parameters:
AXI_DATA_WIDTH, 64, width of the R data bus and of data_read_o
AXI_ADDR_WIDTH, 32, width of the read address

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  asynchronous, active-low reset
r_valid_i  input  1  read request from arbiter
r_addr_i  input  AXI_ADDR_WIDTH  request address
r_len_i  input  8  burst length minus 1
r_size_i  input  3  beat size
r_ready_o  output  1  one-cycle pulse: data_read_o holds a valid beat
data_read_o  output  AXI_DATA_WIDTH  returned beat data
r_last_i  output  1  asserted with r_ready_o on the final beat
arvalid  output  1  AXI AR valid
arready  input  1  AXI AR ready
araddr  output  AXI_ADDR_WIDTH  AXI AR address
arlen  output  8  AXI AR length
arsize  output  3  AXI AR size
rvalid  input  1  AXI R valid
rready  output  1  AXI R ready
rdata  input  AXI_DATA_WIDTH  AXI R data
rlast  input  1  AXI R last
rresp  input  2  AXI R response

Behaviour:
- Clock is clk. Reset rst is asynchronous, active-low. Single clock domain.
- Reset values (every output): arvalid=0, araddr=0, arlen=0, arsize=0, rready=0, r_ready_o=0, r_last_i=0, data_read_o=0. State=IDLE. Beat counter=0.
- State machine has four states: IDLE, ADDR, DATA, DRAIN.
- IDLE:
  - If r_valid_i=1, latch r_addr_i/r_len_i/r_size_i into araddr/arlen/arsize.
  - Assert arvalid on the next cycle and go to ADDR.
- ADDR:
  - arvalid stays high and araddr/arlen/arsize stay stable until arready=1, even if r_valid_i drops (AXI no-retract rule).
  - On arvalid&arready: arvalid<=0, rready<=1, beat counter<=0.
  - Next state is DATA if r_valid_i is still 1, otherwise DRAIN.
- DATA:
  - rready=1 continuously.
  - On each rvalid&rready: data_read_o<=rdata; r_ready_o<=1 for exactly one cycle; r_last_i<=rlast for that same cycle; beat counter increments.
  - When the beat carrying rlast=1 is accepted: rready<=0 and go to IDLE.
  - If r_valid_i falls while in DATA, go to DRAIN on the next cycle.
- DRAIN:
  - rready=1. Accept beats and discard them: r_ready_o stays 0 and data_read_o holds its value.
  - Go to IDLE after the beat carrying rlast.
- Latency:
  - r_valid_i high in IDLE -> arvalid high 1 cycle later.
  - R handshake -> r_ready_o pulse 1 cycle later (registered).
- Back-to-back requests:
  - Minimum gap is 1 IDLE cycle after the last beat.
  - r_valid_i sampled in that IDLE cycle starts a new AR; no request is lost.
- Simultaneous events:
  - rvalid&rlast arriving in the same cycle r_valid_i drops: the beat is still delivered (r_ready_o=1, r_last_i=1), then IDLE.
  - Reset asserted mid-burst: everything returns immediately to reset values. The system must also reset the slave.
- Outputs to the arbiter carry no dependency on rvalid within the same cycle (no combinational path).

Optional Feature:
- Macro: YSYX_22041412_AXI_RCHK_EN.
- Defined:
  - Adds output port rd_err (1 bit, reset 0, sticky until reset).
  - rd_err is set on any accepted beat with rresp!=2'b00.
  - rd_err is set if rlast=1 arrives when beat counter != arlen.
  - rd_err is set if beat counter == arlen and rlast=0; in that case the FSM still waits for rlast.
- Undefined:
  - Port rd_err is absent and no counter comparison is synthesized.
  - Burst end is decided only by rlast; the counter is kept for debug only.

Test Plan:
- Single beat: r_valid_i=1, addr=0x80000000, len=0, size=3; arready after 2 cycles; rdata=0x1122334455667788 with rlast=1 -> araddr=0x80000000, arlen=0; one r_ready_o pulse with r_last_i=1 and data_read_o=0x1122334455667788; back to IDLE.
- Burst of 4: len=3; rvalid stalls 1 cycle between beats, data 0x1..0x4 -> exactly 4 r_ready_o pulses carrying data 0x1,0x2,0x3,0x4; r_last_i only on 0x4.
- Drop during ADDR: r_valid_i falls while arready=0 -> arvalid and araddr held until arready; 2 beats (len=1) drained; r_ready_o never asserts.
- Drop mid-burst: len=7, r_valid_i falls after beat 3 -> beats 1-3 delivered, beats 4-8 absorbed silently, then IDLE; a new request with addr=0x80001000 issues an AR with that address.
- Async reset: rst=0 asserted between clock edges during DATA -> all outputs 0 before the next edge; after release, arvalid=0.
- RCHK_EN defined: len=1 with rresp=2'b10 on beat 2 -> rd_err=1 and held. Separately, len=3 with rlast on beat 2 -> rd_err=1.

Source files
------------

// File: rtl/ysyx_22041412_axi_rd_master.sv
// ysyx_22041412_axi_rd_master: AXI4 read master behind the arbiter read port; dropped bursts complete on the bus and are drained silently.
// Define YSYX_22041412_AXI_RCHK_EN to add a sticky rd_err flag for bad rresp or rlast/arlen mismatch.
module ysyx_22041412_axi_rd_master #(
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ADDR_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      r_valid_i,
    input  logic [AXI_ADDR_WIDTH-1:0] r_addr_i,
    input  logic [7:0]                r_len_i,
    input  logic [2:0]                r_size_i,
    output logic                      r_ready_o,
    output logic [AXI_DATA_WIDTH-1:0] data_read_o,
    output logic                      r_last_i,
    output logic                      arvalid,
    input  logic                      arready,
    output logic [AXI_ADDR_WIDTH-1:0] araddr,
    output logic [7:0]                arlen,
    output logic [2:0]                arsize,
    input  logic                      rvalid,
    output logic                      rready,
    input  logic [AXI_DATA_WIDTH-1:0] rdata,
    input  logic                      rlast,
    input  logic [1:0]                rresp
`ifdef YSYX_22041412_AXI_RCHK_EN
    ,
    output logic                      rd_err
`endif
);
    localparam logic [1:0] IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, DRAIN = 2'd3;
    logic [1:0]                state_q, state_d;
    logic                      arvalid_q, arvalid_d;
    logic [AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [7:0]                arlen_q, arlen_d;
    logic [2:0]                arsize_q, arsize_d;
    logic                      rready_q, rready_d;
    logic                      r_ready_q, r_ready_d;
    logic                      r_last_q, r_last_d;
    logic [AXI_DATA_WIDTH-1:0] data_read_q, data_read_d;
    logic [7:0]                cnt_q, cnt_d;
    logic                      beat;
    assign beat = rvalid & rready_q;
    always_comb begin
        state_d     = state_q;
        arvalid_d   = arvalid_q;
        araddr_d    = araddr_q;
        arlen_d     = arlen_q;
        arsize_d    = arsize_q;
        rready_d    = rready_q;
        cnt_d       = cnt_q;
        data_read_d = data_read_q;
        r_ready_d   = 1'b0;
        r_last_d    = 1'b0;
        case (state_q)
            IDLE: if (r_valid_i) begin
                araddr_d  = r_addr_i;
                arlen_d   = r_len_i;
                arsize_d  = r_size_i;
                arvalid_d = 1'b1;
                state_d   = ADDR;
            end
            ADDR: if (arready) begin
                arvalid_d = 1'b0;
                rready_d  = 1'b1;
                cnt_d     = 8'd0;
                state_d   = r_valid_i ? DATA : DRAIN;
            end
            default: begin
                // DATA forwards accepted beats; DRAIN swallows them until rlast
                if (beat) begin
                    cnt_d = cnt_q + 8'd1;
                    if (state_q == DATA) begin
                        data_read_d = rdata;
                        r_ready_d   = 1'b1;
                        r_last_d    = rlast;
                    end
                end
                rready_d = !(beat && rlast);
                state_d  = (beat && rlast) ? IDLE : (r_valid_i ? state_q : DRAIN);
            end
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            arvalid_q   <= 1'b0;
            araddr_q    <= '0;
            arlen_q     <= 8'd0;
            arsize_q    <= 3'd0;
            rready_q    <= 1'b0;
            r_ready_q   <= 1'b0;
            r_last_q    <= 1'b0;
            data_read_q <= '0;
            cnt_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            arvalid_q   <= arvalid_d;
            araddr_q    <= araddr_d;
            arlen_q     <= arlen_d;
            arsize_q    <= arsize_d;
            rready_q    <= rready_d;
            r_ready_q   <= r_ready_d;
            r_last_q    <= r_last_d;
            data_read_q <= data_read_d;
            cnt_q       <= cnt_d;
        end
    end
`ifdef YSYX_22041412_AXI_RCHK_EN
    logic rd_err_q, rd_err_d;
    always_comb begin
        rd_err_d = rd_err_q | (beat & ((rresp != 2'b00) | (rlast != (cnt_q == arlen_q))));
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rd_err_q <= 1'b0;
        else      rd_err_q <= rd_err_d;
    end
    assign rd_err = rd_err_q;
`else
    logic unused_dbg;
    assign unused_dbg = ^{rresp, cnt_q};
`endif
    assign arvalid     = arvalid_q;
    assign araddr      = araddr_q;
    assign arlen       = arlen_q;
    assign arsize      = arsize_q;
    assign rready      = rready_q;
    assign r_ready_o   = r_ready_q;
    assign r_last_i    = r_last_q;
    assign data_read_o = data_read_q;
endmodule
